// File: rtl/temp_alarm.sv
// temp_alarm: hysteretic over-temperature alarm FSM with persistence filtering and min/max/entry statistics
module temp_alarm #(
  parameter logic [7:0] HI_THRESH = 8'd80,
  parameter logic [7:0] LO_THRESH = 8'd70,
  parameter int PERSIST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] promedio,
  input  logic       sample,
  input  logic       clr_stats,
  output logic [1:0] state,
  output logic       alarm,
  output logic [7:0] max_temp,
  output logic [7:0] min_temp,
  output logic [7:0] alarm_count
);
  typedef enum logic [1:0] {NORMAL = 2'b00, PENDING = 2'b01, ALARM = 2'b10, COOLDOWN = 2'b11} state_t;
  localparam logic [3:0] LAST = 4'(PERSIST - 1);
  state_t st;
  logic [3:0] cnt;
  logic hot, cool, last, entry;
  assign hot = promedio >= HI_THRESH;
  assign cool = promedio <= LO_THRESH;
  assign last = cnt == LAST;
  assign entry = sample && st == PENDING && hot && last;
  assign state = st;
  assign alarm = st[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= NORMAL;
      cnt <= 4'd0;
      max_temp <= 8'h00;
      min_temp <= 8'hff;
      alarm_count <= 8'd0;
    end else begin
      if (sample)
        case (st)
          NORMAL: begin
            st <= hot ? PENDING : NORMAL;
            cnt <= hot ? 4'd1 : 4'd0;
          end
          PENDING: begin
            st <= !hot ? NORMAL : last ? ALARM : PENDING;
            cnt <= (!hot || last) ? 4'd0 : cnt + 4'd1;
          end
          ALARM: begin
            st <= cool ? COOLDOWN : ALARM;
            cnt <= cool ? 4'd1 : 4'd0;
          end
          COOLDOWN: begin
            st <= !cool ? ALARM : last ? NORMAL : COOLDOWN;
            cnt <= (!cool || last) ? 4'd0 : cnt + 4'd1;
          end
        endcase
      if (clr_stats) begin
        max_temp <= 8'h00;
        min_temp <= 8'hff;
        alarm_count <= 8'd0;
      end else if (sample) begin
        max_temp <= promedio > max_temp ? promedio : max_temp;
        min_temp <= promedio < min_temp ? promedio : min_temp;
        alarm_count <= (entry && alarm_count != 8'hff) ? alarm_count + 8'd1 : alarm_count;
      end
    end
  end
endmodule

// File: doc/temp_alarm.md
TEMP_ALARM -- requirements
Module: temp_alarm

Interface
- REQ-001 SHALL have parameter HI_THRESH, default 8'd80: unsigned alarm-entry threshold; average >= HI_THRESH counts as hot.
- REQ-002 SHALL have parameter LO_THRESH, default 8'd70: unsigned alarm-exit threshold; average <= LO_THRESH counts as cool; LO_THRESH < HI_THRESH is required.
- REQ-003 SHALL have parameter PERSIST, default 4: number of consecutive qualifying samples needed to change state; legal range 2..15.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 SHALL have port promedio, input, 8 bits: unsigned averaged temperature from the averaging stage.
- REQ-007 SHALL have port sample, input, 1 bit: one-cycle strobe; promedio is valid and consumed in that cycle.
- REQ-008 SHALL have port clr_stats, input, 1 bit: synchronous clear of the statistics registers.
- REQ-009 SHALL have port state, output, 2 bits: FSM state, with NORMAL=00, PENDING=01, ALARM=10, COOLDOWN=11.
- REQ-010 SHALL have port alarm, output, 1 bit: high while state is ALARM or COOLDOWN.
- REQ-011 SHALL have port max_temp, output, 8 bits: highest sampled promedio since the last clear.
- REQ-012 SHALL have port min_temp, output, 8 bits: lowest sampled promedio since the last clear.
- REQ-013 SHALL have port alarm_count, output, 8 bits: number of ALARM entries, saturating at 255.

Function
- REQ-014 SHALL use an internal persistence counter, cnt, 4 bits wide; all comparisons are unsigned 8-bit.
- REQ-015 SHALL change state and cnt only on clock edges where sample=1; cycles with sample=0 hold all state.
- REQ-016 SHALL use registered outputs; the effect of a sample is visible one clock after the accepting edge, i.e. latency 1.
- REQ-017 NORMAL: hot sample -> PENDING with cnt=1; otherwise stay in NORMAL with cnt=0.
- REQ-018 PENDING: hot sample with cnt+1 == PERSIST -> ALARM, cnt=0, alarm_count += 1 (saturating).
- REQ-019 PENDING: hot sample with cnt+1 < PERSIST -> cnt += 1; non-hot sample -> NORMAL with cnt=0.
- REQ-020 ALARM: cool sample -> COOLDOWN with cnt=1; otherwise stay in ALARM.
- REQ-021 COOLDOWN: cool sample with cnt+1 == PERSIST -> NORMAL with cnt=0.
- REQ-022 COOLDOWN: cool sample with cnt+1 < PERSIST -> cnt += 1; non-cool sample -> ALARM with cnt=0 and no alarm_count increment.
- REQ-023 Hysteresis: a sample with LO_THRESH < promedio < HI_THRESH is neither hot nor cool.
- REQ-024 On each sample: max_temp = max(max_temp, promedio) and min_temp = min(min_temp, promedio).
- REQ-025 clr_stats=1 sets max_temp=0x00, min_temp=0xFF and alarm_count=0 on the next edge; it has priority over a simultaneous stats update.
- REQ-026 clr_stats has no effect on state, cnt or alarm; a sample in the same cycle still advances the FSM.
- REQ-027 With alarm_count=255, a further ALARM entry leaves it at 255.
- REQ-028 Boundaries: promedio == HI_THRESH is hot; promedio == LO_THRESH is cool; 0x00 and 0xFF are legal inputs.

Reset
- REQ-029 rst=1 SHALL immediately, without waiting for a clock, force state=NORMAL, cnt=0, alarm=0, max_temp=0x00, min_temp=0xFF and alarm_count=0.
- REQ-030 Reset asserted mid-sequence, in any state, SHALL abandon that sequence; the first sample after deassertion is evaluated from NORMAL.
- REQ-031 SHALL keep all outputs at reset values while rst=1, regardless of sample or clr_stats.

Verification
- REQ-032 Entry: 4 samples of 80 -> state 01 after samples 1-3, 10 after sample 4; alarm=1 and alarm_count=1 one clock after sample 4.
- REQ-033 Aborted pend: samples 85, 85, 85, 79 -> state returns to 00; alarm_count=0; max_temp=85, min_temp=79.
- REQ-034 Exit with hysteresis: from ALARM, samples 75 x10 -> stays 10; then 70, 70, 71 -> 11, 11, 10; then 70 x4 -> 00 after the 4th, alarm=0.
- REQ-035 Clear: clr_stats and sample(50) in the same cycle -> max_temp=0x00, min_temp=0xFF, alarm_count=0; next sample(50) -> max_temp=50, min_temp=50.
- REQ-036 Async reset: assert rst between clock edges while in COOLDOWN -> outputs reach reset values before the next edge; after release, 3 samples of 90 -> state 01, not 10.
- REQ-037 Saturation: 256 ALARM entry/exit cycles -> alarm_count holds at 255.
